// File: rtl/rsa16_pkg.sv
// Shared definitions for the RSA16 modular-exponentiation sequencer.
//   - default exponent / index widths
//   - multiplier operand-select encodings
//   - sequencer state enumeration
package rsa16_pkg;

    localparam int EW_DEF = 16;  // exponent width and iteration count
    localparam int IW_DEF = 4;   // index width, clog2(EW_DEF)

    // Multiplier operand select
    localparam logic MM_SEL_SQR = 1'b0;  // R*R
    localparam logic MM_SEL_MUL = 1'b1;  // R*M

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT     = 4'd1,
        ST_SQR_GO   = 4'd2,
        ST_SQR_WAIT = 4'd3,
        ST_SQR_WB   = 4'd4,
        ST_MUL_GO   = 4'd5,
        ST_MUL_WAIT = 4'd6,
        ST_MUL_WB   = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    // True in the three states of a multiply operation
    function automatic logic is_mul_state(input state_t s);
        return (s == ST_MUL_GO) || (s == ST_MUL_WAIT) || (s == ST_MUL_WB);
    endfunction

endpackage

// File: rtl/ltp.sv
// Level-to-pulse converter.
// Turns the rising edge of a software-held level into a single registered
// one-cycle pulse, appearing one cycle after the level is first sampled high.
// Ports:
//   i_clk    clock
//   i_rstn   asynchronous active-low reset
//   i_level  level input
//   o_pulse  one-cycle pulse per rising edge of i_level
module ltp (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_level,
    output logic o_pulse
);

    logic level_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            level_q <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            level_q <= i_level;
            o_pulse <= i_level & ~level_q;
        end
    end

endmodule

// File: rtl/rsa16_modexp_ctrl.sv
// Sequencer for the RSA16 modular-exponentiation datapath.
// Computes R = M^E mod N by left-to-right square-and-multiply (MSB first),
// driving the shared modular multiplier and the R register write enables.
// Ports:
//   i_clk, i_rstn  clock, asynchronous active-low reset
//   i_start        start level; its rising edge starts an operation
//   i_abort        synchronous abort back to IDLE
//   i_exp          exponent, captured when the start is accepted
//   i_mm_done      multiplier result-valid pulse
//   o_mm_start     multiplier start pulse
//   o_mm_sel       multiplier operands: 0 = R*R, 1 = R*M
//   o_r_init       load R<=1, M<=base
//   o_r_we         R <= multiplier result
//   o_busy         high outside IDLE
//   o_done         final-result pulse
//   o_bit_idx      exponent bit currently processed
module rsa16_modexp_ctrl
    import rsa16_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [EW-1:0] i_exp,
    input  logic          i_mm_done,
    output logic          o_mm_start,
    output logic          o_mm_sel,
    output logic          o_r_init,
    output logic          o_r_we,
    output logic          o_busy,
    output logic          o_done,
    output logic [IW-1:0] o_bit_idx
);

    state_t        state_q, state_d;
    logic [EW-1:0] exp_q;
    logic [IW-1:0] idx_q;
    logic          start_p;
    logic          load_op;  // capture exponent and reset the bit index
    logic          dec_idx;  // move on to the next lower exponent bit

    ltp u_ltp (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_level (i_start),
        .o_pulse (start_p)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_op) begin
                exp_q <= i_exp;
                idx_q <= IW'(EW - 1);
            end else if (dec_idx) begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        load_op = 1'b0;
        dec_idx = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A start pulse while busy lands in another state and is dropped.
                if (start_p) begin
                    state_d = ST_INIT;
                    load_op = 1'b1;
                end
            end
            ST_INIT:     state_d = (exp_q == '0) ? ST_DONE : ST_SQR_GO;
            ST_SQR_GO:   state_d = ST_SQR_WAIT;
            ST_SQR_WAIT: if (i_mm_done) state_d = ST_SQR_WB;
            ST_SQR_WB: begin
                if (exp_q[idx_q]) begin
                    state_d = ST_MUL_GO;
                end else if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SQR_GO;
                    dec_idx = 1'b1;
                end
            end
            ST_MUL_GO:   state_d = ST_MUL_WAIT;
            ST_MUL_WAIT: if (i_mm_done) state_d = ST_MUL_WB;
            ST_MUL_WB: begin
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SQR_GO;
                    dec_idx = 1'b1;
                end
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Abort wins over everything, including a start pulse in IDLE.
        if (i_abort) begin
            state_d = ST_IDLE;
            load_op = 1'b0;
            dec_idx = 1'b0;
        end
    end

    // Moore outputs: decoded from registered state only.
    assign o_mm_start = (state_q == ST_SQR_GO) || (state_q == ST_MUL_GO);
    assign o_mm_sel   = is_mul_state(state_q) ? MM_SEL_MUL : MM_SEL_SQR;
    assign o_r_init   = (state_q == ST_INIT);
    assign o_r_we     = (state_q == ST_SQR_WB) || (state_q == ST_MUL_WB);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
    assign o_bit_idx  = idx_q;

endmodule

// File: tb/tb_rsa16_modexp_ctrl.sv
// Self-checking bench for rsa16_modexp_ctrl.
// A multiplier model answers every o_mm_start after L cycles and also emulates
// the R/M datapath, so the final R can be compared against M^E mod N computed
// independently by right-to-left exponentiation.
module tb_rsa16_modexp_ctrl;

    localparam int EW = 16;
    localparam int IW = 4;
    localparam int L  = 3;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [EW-1:0] i_exp = '0;
    logic          i_mm_done = 1'b0;
    logic          o_mm_start, o_mm_sel, o_r_init, o_r_we, o_busy, o_done;
    logic [IW-1:0] o_bit_idx;

    rsa16_modexp_ctrl #(.EW(EW), .IW(IW)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_exp      (i_exp),
        .i_mm_done  (i_mm_done),
        .o_mm_start (o_mm_start),
        .o_mm_sel   (o_mm_sel),
        .o_r_init   (o_r_init),
        .o_r_we     (o_r_we),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bit_idx  (o_bit_idx)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({o_mm_start, o_mm_sel, o_r_init, o_r_we, o_busy, o_done, o_bit_idx});
    endfunction

    // Independent reference: right-to-left binary exponentiation.
    function automatic logic [31:0] modexp_ref(input logic [15:0] m, input logic [15:0] e,
                                               input logic [15:0] n);
        logic [31:0] res, base, nn;
        nn   = 32'(n);
        res  = 32'd1;
        base = 32'(m) % nn;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) res = (res * base) % nn;
            base = (base * base) % nn;
        end
        return res;
    endfunction

    // ---------------- multiplier model (drives i_mm_done) ----------------
    int bfm_cnt = 0;
    bit spur_now = 1'b0;    // inject one done pulse at the next opportunity
    bit spur_on_go = 1'b0;  // inject one done pulse during the next *_GO cycle

    initial forever begin
        @(negedge i_clk);
        i_mm_done = 1'b0;
        if (bfm_cnt > 0) begin
            bfm_cnt--;
            if (bfm_cnt == 0) i_mm_done = 1'b1;
        end
        if (spur_now) begin
            i_mm_done = 1'b1;
            spur_now  = 1'b0;
        end
        if (o_mm_start === 1'b1) begin
            bfm_cnt = L;
            if (spur_on_go) begin
                i_mm_done  = 1'b1;
                spur_on_go = 1'b0;
            end
        end
    end

    // ---------------- monitor / datapath emulation ----------------
    int          cyc = 0;
    int          init_cnt, start_cnt, we_cnt, done_cnt, init_cyc, done_cyc;
    logic [31:0] r_model, prod;
    logic [15:0] tb_m = 16'd3;
    logic [15:0] tb_n = 16'd7;
    bit          sel_log[$];
    int          idx_log[$];

    initial forever begin
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_r_init === 1'b1) begin
            init_cnt++;
            init_cyc = cyc;
            r_model  = 32'd1;
        end
        if (o_mm_start === 1'b1) begin
            start_cnt++;
            sel_log.push_back(o_mm_sel);
            idx_log.push_back(int'(o_bit_idx));
            prod = o_mm_sel ? (r_model * 32'(tb_m)) % 32'(tb_n)
                            : (r_model * r_model) % 32'(tb_n);
        end
        if (o_r_we === 1'b1) begin
            we_cnt++;
            r_model = prod;
        end
        if (o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_stats();
        init_cnt  = 0;
        start_cnt = 0;
        we_cnt    = 0;
        done_cnt  = 0;
        init_cyc  = 0;
        done_cyc  = 0;
        r_model   = 32'd0;
        sel_log.delete();
        idx_log.delete();
    endtask

    // One full operation, checked against the square-and-multiply schedule.
    task automatic run_op(input string tag, input logic [15:0] e, input logic [15:0] m,
                          input logic [15:0] n, input bit toggle_mid, input int hold);
        int k, pop, nops, mism, j, start_snap;
        bit exp_sel[$];
        int exp_idx[$];
        clear_stats();
        tb_m    = m;
        tb_n    = n;
        i_exp   = e;
        i_start = 1'b1;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge i_clk);
            k++;
            if (k == 3) i_exp = ~e;            // exponent must already be captured
            if (toggle_mid && k == 20) i_start = 1'b0;
            if (toggle_mid && k == 22) i_start = 1'b1;  // rising edge while busy
        end
        check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);

        for (int i = EW - 1; i >= 0; i--) begin
            exp_sel.push_back(1'b0);
            exp_idx.push_back(i);
            if (e[i]) begin
                exp_sel.push_back(1'b1);
                exp_idx.push_back(i);
            end
        end
        pop  = $countones(e);
        nops = (e == 16'h0) ? 0 : EW + pop;
        mism = 0;
        j    = 0;
        while (j < exp_sel.size() && j < sel_log.size() && nops != 0) begin
            if (sel_log[j] != exp_sel[j] || idx_log[j] != exp_idx[j]) mism++;
            j++;
        end
        check({tag, "_r_init"}, 32'(init_cnt), 32'd1);
        check({tag, "_mm_starts"}, 32'(start_cnt), 32'(nops));
        check({tag, "_r_we"}, 32'(we_cnt), 32'(nops));
        check({tag, "_op_seq_mismatch"}, 32'(mism), 32'd0);
        check({tag, "_cycles"}, 32'(done_cyc - init_cyc + 1),
              (e == 16'h0) ? 32'd2 : 32'(2 + nops * (L + 2)));
        check({tag, "_result"}, r_model, modexp_ref(m, e, n));

        if (hold > 0) begin
            start_snap = start_cnt;
            repeat (hold) @(negedge i_clk);
            check({tag, "_held_no_restart"}, 32'(init_cnt), 32'd1);
            check({tag, "_held_no_mm"}, 32'(start_cnt), 32'(start_snap));
            check({tag, "_held_idle"}, 32'(o_busy), 32'd0);
        end
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    function automatic logic [15:0] rand_n();
        return 16'(2 + $urandom_range(65533));
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  found;
        logic [15:0] e;

        clear_stats();
        // Reset state
        repeat (3) @(negedge i_clk);
        check("reset_outputs_low", all_outputs(), 32'd0);
        i_rstn = 1'b1;
        repeat (2) @(negedge i_clk);
        check("after_reset_outputs", all_outputs(), 32'd0);

        // Directed exponents
        run_op("e0000", 16'h0000, 16'd1234, 16'd4567, 1'b0, 0);
        run_op("e0001", 16'h0001, 16'd1234, 16'd4567, 1'b0, 0);
        run_op("effff", 16'hFFFF, 16'd4321, 16'd65521, 1'b0, 0);
        check("bit_idx_after_op", 32'(o_bit_idx), 32'd0);

        // Randomized exponents and operands
        for (int r = 0; r < 4; r++)
            run_op("rand", 16'($urandom), 16'($urandom), rand_n(), 1'b0, 0);

        // Held start level plus a second rising edge while busy
        run_op("held", 16'($urandom), 16'($urandom), rand_n(), 1'b1, 200);

        // Spurious multiplier done while idle
        clear_stats();
        spur_now = 1'b1;
        repeat (4) @(negedge i_clk);
        check("spur_idle_busy", 32'(o_busy), 32'd0);
        check("spur_idle_no_we", 32'(we_cnt), 32'd0);
        check("spur_idle_no_init", 32'(init_cnt), 32'd0);

        // Spurious done during the first square's GO cycle
        spur_on_go = 1'b1;
        run_op("spur_go", 16'($urandom) | 16'h8001, 16'($urandom), rand_n(), 1'b0, 0);

        // Abort at bit 7 while waiting on a multiply
        clear_stats();
        e       = 16'($urandom) | 16'h0080;
        tb_m    = 16'($urandom);
        tb_n    = rand_n();
        i_exp   = e;
        i_start = 1'b1;
        k       = 0;
        found   = 1'b0;
        while (!found && k < 3000) begin
            @(negedge i_clk);
            k++;
            if (o_busy && o_mm_sel && !o_mm_start && !o_r_we && o_bit_idx == 4'd7) found = 1'b1;
        end
        check("abort_reached_mul_wait_idx7", 32'(found), 32'd1);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_busy_low", 32'(o_busy), 32'd0);
        check("abort_no_done_now", 32'(o_done), 32'd0);
        repeat (10) @(negedge i_clk);
        check("abort_no_done_later", 32'(done_cnt), 32'd0);
        check("abort_stays_idle", 32'(o_busy), 32'd0);
        i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        run_op("after_abort", 16'($urandom), 16'($urandom), rand_n(), 1'b0, 0);

        // Asynchronous reset in the middle of an operation
        clear_stats();
        i_exp   = 16'hA5A5;
        i_start = 1'b1;
        repeat (30) @(negedge i_clk);
        check("midop_busy_before_reset", 32'(o_busy), 32'd1);
        i_rstn = 1'b0;
        #1;
        check("midop_reset_outputs_low", all_outputs(), 32'd0);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (2) @(negedge i_clk);
        check("post_reset_idle", all_outputs(), 32'd0);
        run_op("after_reset", 16'($urandom), 16'($urandom), rand_n(), 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
